store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised store unit between the MEM stage and the data-memory port. Decodes SB/SH/SW into byte enables and lane-replicated write data, and flags misaligned stores combinationally so they can be raised as AdES. Queues legal stores in a DEPTH-entry FIFO drained over a req/ack handshake. Provides a word-address hazard check for younger loads.

## Interface
- DATA_W, 32: memory data width; legal values are 32 and 64. LANES = DATA_W/8.
- ADDR_W, 32: byte address width.
- DEPTH, 4: number of FIFO entries; must be a power of two, at least 2.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- st_valid  in  1  store presented by MEM stage.
- st_ready  out  1  store can be accepted this cycle.
- st_op  in  6  MIPS opcode.
- st_addr  in  ADDR_W  byte address.
- st_wdata  in  32  rt value.
- ades  out  1  misaligned store on the current request (combinational).
- badvaddr  out  ADDR_W  equals st_addr whenever ades=1, otherwise 0.
- mem_req  out  1  head entry valid.
- mem_addr  out  ADDR_W  head address with low log2(LANES) bits forced to 0.
- mem_we  out  LANES  head byte enables.
- mem_wdata  out  DATA_W  head data.
- mem_ack  in  1  head consumed this cycle.
- ld_addr  in  ADDR_W  load address to check.
- ld_hazard  out  1  a pending or incoming store covers the same aligned word.
- sb_empty  out  1  no entries held.
- sb_count  out  log2(DEPTH)+1  occupancy.

## Operation
- Opcodes: SB=6'b101000, SH=6'b101001, SW=6'b101011. Any other opcode with st_valid=1 is ignored: no push, ades=0.
- Let k = st_addr[log2(LANES)-1:0].
- SB: we = one-hot at lane k; data = st_wdata[7:0] replicated across all lanes.
- SH: requires st_addr[0]=0. we = 2'b11 << k; data = st_wdata[15:0] replicated.
- SW: requires st_addr[1:0]=0. we = 4'hF << k; data = st_wdata replicated.
- Misaligned SH/SW: ades=1 and the store is dropped. st_ready is unaffected.
- Push: st_valid && st_ready && legal store -> write to tail entry; count+1.
- Pop: mem_req && mem_ack -> advance head; count-1.
- st_ready = (count != DEPTH).
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- The head entry's address, we and data must stay stable while mem_req=1 and mem_ack=0.
- mem_ack while mem_req=0 is ignored.
- ld_hazard: OR over all valid entries and the incoming legal store of (entry word address == ld_addr word address). Word address drops the low log2(LANES) bits. Combinational.
- Reset (resetn=0, any time): count=0, pointers=0, all entries invalid, mem_req=0, mem_we=0, sb_empty=1, st_ready=1. Any in-flight head is discarded; the memory side must also be reset.

## Timing
- Push to mem_req: 1 cycle. A store accepted at edge N is presented from N+1 when the buffer was empty.
- Throughput: 1 store/cycle in, 1 store/cycle out with mem_ack held high.
- ades, badvaddr, st_ready and ld_hazard are combinational from inputs and registered state in the same cycle.
- All other outputs are registered state.

## Configuration
- STORE_BUF_MERGE_EN defined: store merging is enabled.
  - Merge condition: a legal store whose word address equals the tail-most valid entry, with count >= 2 (so the tail is not the head).
  - Effect: merges into that entry. we |= new we; the new bytes overwrite only their own lanes.
  - count does not change; the store is accepted even when full.
  - Never merges into the head entry.
- STORE_BUF_MERGE_EN undefined: every legal store allocates a new entry.

## Structure
- Shared package mem_defs:
  - opcode constants OP_SB, OP_SH, OP_SW.
  - LANES derivation.
  - store entry typedef: addr, we, data.
- Sub-module store_align, purely combinational: op, addr and wdata in; we, aligned data and ades out. Parametrised by DATA_W.
- store_buffer holds the FIFO, pointers, merge logic and hazard compare.

## Test plan
- DATA_W=32, SB at 0x1003 with wdata 0x000000AB -> next cycle mem_req=1, mem_addr=0x1000, mem_we=4'b1000, mem_wdata=0xABABABAB.
- SH at 0x2001 -> ades=1, badvaddr=0x2001, count stays 0. SW at 0x2004 in the next cycle -> accepted, mem_we=4'hF.
- DATA_W=64, SW at 0x3004 with wdata 0x12345678 -> mem_we=8'hF0, mem_addr=0x3000, mem_wdata=0x1234567812345678.
- DEPTH=4, mem_ack=0, five SWs -> st_ready=0 after the fourth and the fifth is held. One mem_ack pulse -> st_ready=1 and the fifth is accepted; count=4.
- Merge enabled: SW to 0x4000 and SW to 0x5000 with ack held low, then SB 0xCD at 0x5001 -> count stays 2; on the second pop mem_we=4'hF and byte 1 = 0xCD. Merge disabled -> count=3.
- Pending store at 0x6008 with ld_addr=0x600B -> ld_hazard=1; ld_addr=0x600C -> 0. Assert resetn=0 mid-drain -> mem_req=0 and sb_empty=1 immediately.

Source files
------------

// File: rtl/mem_defs.sv
// Shared store-path definitions: MIPS store opcodes and lane math.
// Imported by store_align and store_buffer.
package mem_defs;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int offs_of(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Store entry for the default 32-bit address / 32-bit data build.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Store decoder: byte enables, lane-replicated data and AdES detect.
// Purely combinational, parametrised by memory data width.
module store_align
  import mem_defs::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = lanes_of(DATA_W),
  localparam int OW     = offs_of(DATA_W)
) (
  input  logic [5:0]        op_i,
  input  logic [OW-1:0]     off_i,
  input  logic [31:0]       wdata_i,
  output logic [LANES-1:0]  we_o,
  output logic [DATA_W-1:0] data_o,
  output logic              legal_o,
  output logic              ades_o
);

  // Decode opcode, check alignment, shift enables into place
  always_comb begin
    we_o    = '0;
    data_o  = '0;
    legal_o = 1'b0;
    ades_o  = 1'b0;
    unique case (1'b1)
      (op_i == OP_SB): begin
        legal_o = 1'b1;
        we_o    = LANES'(1) << off_i;
        data_o  = {LANES{wdata_i[7:0]}};
      end
      (op_i == OP_SH): begin
        if (off_i[0]) begin
          ades_o = 1'b1;
        end else begin
          legal_o = 1'b1;
          we_o    = LANES'(3) << off_i;
          data_o  = {(LANES/2){wdata_i[15:0]}};
        end
      end
      (op_i == OP_SW): begin
        if (off_i[1:0] != 2'b00) begin
          ades_o = 1'b1;
        end else begin
          legal_o = 1'b1;
          we_o    = LANES'(15) << off_i;
          data_o  = {(LANES/4){wdata_i}};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between MEM stage and data memory, with load hazard check.
// Optional STORE_BUF_MERGE_EN merges same-word stores into the tail.
module store_buffer
  import mem_defs::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 4,
  localparam int LANES  = lanes_of(DATA_W),
  localparam int OW     = offs_of(DATA_W),
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [5:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              sb_empty,
  output logic [CW-1:0]     sb_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  we;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [ADDR_W-1:0] WMASK =
    {{(ADDR_W-OW){1'b1}}, {OW{1'b0}}};

  entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [LANES-1:0]  a_we;
  logic [DATA_W-1:0] a_data;
  logic              a_legal, a_ades;
  logic [ADDR_W-1:0] st_al, ld_al;
  logic              req_ok, full;
  logic              merge_hit, push, pop;

  store_align #(.DATA_W(DATA_W)) u_align (
    .op_i    (st_op),
    .off_i   (st_addr[OW-1:0]),
    .wdata_i (st_wdata),
    .we_o    (a_we),
    .data_o  (a_data),
    .legal_o (a_legal),
    .ades_o  (a_ades)
  );

  assign st_al  = st_addr & WMASK;
  assign ld_al  = ld_addr & WMASK;
  assign req_ok = st_valid & a_legal;
  assign full   = (count_q == CW'(DEPTH));

`ifdef STORE_BUF_MERGE_EN
  logic [PW-1:0]     last;
  logic [DATA_W-1:0] merge_data;

  // Tail-most entry; never the head once two or more are held
  assign last      = tail_q - 1'b1;
  assign merge_hit = req_ok && (count_q >= CW'(2)) &&
                     (ent_q[last].addr == st_al);

  // New bytes overwrite only their own lanes of the tail entry
  always_comb begin
    merge_data = ent_q[last].data;
    for (int l = 0; l < LANES; l++) begin
      if (a_we[l]) merge_data[8*l +: 8] = a_data[8*l +: 8];
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready = ~full | merge_hit;
  assign push     = req_ok & ~full & ~merge_hit;
  assign mem_req  = (count_q != '0);
  assign pop      = mem_req & mem_ack;

  assign ades     = st_valid & a_ades;
  assign badvaddr = ades ? st_addr : '0;

  assign mem_addr  = ent_q[head_q].addr;
  assign mem_we    = mem_req ? ent_q[head_q].we : '0;
  assign mem_wdata = ent_q[head_q].data;
  assign sb_empty  = ~mem_req;
  assign sb_count  = count_q;

  // Pointer and occupancy next state
  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Same aligned word held in any entry or arriving now
  always_comb begin
    ld_hazard = req_ok && (st_al == ld_al);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].addr == ld_al)) ld_hazard = 1'b1;
    end
  end

  // FIFO storage, valid bits and pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        ent_q[tail_q] <= '{addr: st_al, we: a_we, data: a_data};
        vld_q[tail_q] <= 1'b1;
      end
`ifdef STORE_BUF_MERGE_EN
      if (merge_hit) begin
        ent_q[last].we   <= ent_q[last].we | a_we;
        ent_q[last].data <= merge_data;
      end
`endif
      if (pop) vld_q[head_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer (32-bit and 64-bit data instances).
// Expected stores are queued at issue and checked at each mem handshake.
module tb_store_buffer;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit instance
  logic        s_valid, s_ready, s_ades, r_req, r_ack, r_haz, r_empty;
  logic [5:0]  s_op;
  logic [31:0] s_addr, s_wdata, s_bad, r_addr, r_wdata, ld;
  logic [3:0]  r_we;
  logic [2:0]  r_cnt;

  // 64-bit instance
  logic        w_valid, w_ready, w_ades, w_req, w_ack, w_haz, w_empty;
  logic [5:0]  w_op;
  logic [31:0] w_addr, w_wd, w_bad, w_maddr, w_ld;
  logic [7:0]  w_we;
  logic [63:0] w_mwd;
  logic [2:0]  w_cnt;

  store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u32 (
    .clk(clk), .resetn(rn),
    .st_valid(s_valid), .st_ready(s_ready), .st_op(s_op),
    .st_addr(s_addr), .st_wdata(s_wdata),
    .ades(s_ades), .badvaddr(s_bad),
    .mem_req(r_req), .mem_addr(r_addr), .mem_we(r_we),
    .mem_wdata(r_wdata), .mem_ack(r_ack),
    .ld_addr(ld), .ld_hazard(r_haz),
    .sb_empty(r_empty), .sb_count(r_cnt)
  );

  store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) u64 (
    .clk(clk), .resetn(rn),
    .st_valid(w_valid), .st_ready(w_ready), .st_op(w_op),
    .st_addr(w_addr), .st_wdata(w_wd),
    .ades(w_ades), .badvaddr(w_bad),
    .mem_req(w_req), .mem_addr(w_maddr), .mem_we(w_we),
    .mem_wdata(w_mwd), .mem_ack(w_ack),
    .ld_addr(w_ld), .ld_hazard(w_haz),
    .sb_empty(w_empty), .sb_count(w_cnt)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] LW = 6'b100011;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    s_valid = 1'b1;
    s_op    = op;
    s_addr  = a;
    s_wdata = d;
  endtask

  task automatic expect_st(input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] d);
    exp_t e;
    e.a  = a;
    e.we = we;
    e.d  = d;
    q.push_back(e);
  endtask

  // Monitor: compare head against scoreboard on each accepted handshake
  always @(negedge clk) begin
    if (rn && r_req && r_ack) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: unexpected store addr=%h we=%h data=%h",
                 r_addr, r_we, r_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (r_addr !== e.a || r_we !== e.we || r_wdata !== e.d) begin
          errors++;
          $display("FAIL sb_pop: got addr=%h we=%h data=%h expected addr=%h we=%h data=%h",
                   r_addr, r_we, r_wdata, e.a, e.we, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    s_valid = 0; s_op = '0; s_addr = '0; s_wdata = '0;
    r_ack = 0; ld = 32'hFFFF_FFF0;
    w_valid = 0; w_op = '0; w_addr = '0; w_wd = '0;
    w_ack = 0; w_ld = 32'hFFFF_FFF0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", r_empty, 1);
    chk("rst_ready", s_ready, 1);
    chk("rst_req", r_req, 0);
    chk("rst_we", r_we, 0);
    chk("rst_count", r_cnt, 0);
    @(posedge clk); #1;
    rn = 1'b1;

    // SB at 0x1003
    tick();
    drive(SB, 32'h1003, 32'h0000_00AB);
    expect_st(32'h1000, 4'b1000, 32'hABAB_ABAB);
    @(negedge clk);
    chk("sb_ades", s_ades, 0);
    chk("sb_req_before", r_req, 0);
    tick();
    s_valid = 0;
    @(negedge clk);
    chk("sb_req", r_req, 1);
    chk("sb_addr", r_addr, 32'h1000);
    chk("sb_we", r_we, 4'b1000);
    chk("sb_data", r_wdata, 32'hABAB_ABAB);
    tick();
    r_ack = 1;
    tick();
    r_ack = 0;
    @(negedge clk);
    chk("sb_drained", r_empty, 1);

    // Misaligned SH, then aligned SW, then non-store opcode
    tick();
    drive(SH, 32'h2001, 32'h0000_1234);
    @(negedge clk);
    chk("sh_ades", s_ades, 1);
    chk("sh_badv", s_bad, 32'h2001);
    chk("sh_ready", s_ready, 1);
    tick();
    drive(SW, 32'h2004, 32'hDEAD_BEEF);
    expect_st(32'h2004, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_ades", s_ades, 0);
    chk("sw_badv", s_bad, 0);
    chk("sh_dropped", r_cnt, 0);
    tick();
    drive(LW, 32'h2002, 32'h1);
    @(negedge clk);
    chk("sw_count", r_cnt, 1);
    chk("sw_we", r_we, 4'hF);
    chk("lw_ades", s_ades, 0);
    tick();
    s_valid = 0;
    @(negedge clk);
    chk("lw_ignored", r_cnt, 1);
    tick();
    r_ack = 1;
    tick();
    r_ack = 0;

    // 64-bit SW at 0x3004
    w_valid = 1; w_op = SW; w_addr = 32'h3004; w_wd = 32'h1234_5678;
    w_ld = 32'h3000;
    @(negedge clk);
    chk("w_haz_in", w_haz, 1);
    tick();
    w_valid = 0;
    @(negedge clk);
    chk("w_we", w_we, 8'hF0);
    chk("w_addr", w_maddr, 32'h3000);
    chk("w_data", w_mwd, 64'h1234_5678_1234_5678);
    chk("w_haz_held", w_haz, 1);
    tick();
    w_ack = 1;
    tick();
    w_ack = 0;
    @(negedge clk);
    chk("w_empty", w_empty, 1);
    chk("w_cnt", w_cnt, 0);
    chk("w_ready", w_ready, 1);
    chk("w_ades", w_ades, 0);
    chk("w_badv", w_bad, 0);

    // Fill to DEPTH with ack low; fifth store held
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(SW, 32'h7000 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk);
      chk($sformatf("fill_ready%0d", i), s_ready, (i < 4) ? 1 : 0);
      if (i < 4) expect_st(32'h7000 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
      tick();
    end
    ld = 32'h700B;
    @(negedge clk);
    chk("full_count", r_cnt, 4);
    chk("full_ready", s_ready, 0);
    chk("full_haz", r_haz, 1);
    tick();
    r_ack = 1;
    tick();
    r_ack = 0;
    expect_st(32'h7010, 4'hF, 32'hA4);
    @(negedge clk);
    chk("ack_ready", s_ready, 1);
    chk("ack_count", r_cnt, 3);
    tick();
    s_valid = 0;
    @(negedge clk);
    chk("fifth_count", r_cnt, 4);
    tick();
    r_ack = 1;
    repeat (4) tick();
    r_ack = 0;
    @(negedge clk);
    chk("fill_drained", r_empty, 1);

    // Same-word store after a non-head tail
    tick();
    drive(SW, 32'h4000, 32'h0102_0304);
    expect_st(32'h4000, 4'hF, 32'h0102_0304);
    tick();
    drive(SW, 32'h5000, 32'h1122_3344);
`ifdef STORE_BUF_MERGE_EN
    expect_st(32'h5000, 4'hF, 32'h1122_CD44);
`else
    expect_st(32'h5000, 4'hF, 32'h1122_3344);
`endif
    tick();
    drive(SB, 32'h5001, 32'h0000_00CD);
`ifndef STORE_BUF_MERGE_EN
    expect_st(32'h5000, 4'b0010, 32'hCDCD_CDCD);
`endif
    tick();
    s_valid = 0;
    @(negedge clk);
`ifdef STORE_BUF_MERGE_EN
    chk("merge_count", r_cnt, 2);
`else
    chk("merge_count", r_cnt, 3);
`endif
    tick();
    r_ack = 1;
    for (int i = 0; i < 8; i++) begin
      if (r_empty) break;
      tick();
    end
    r_ack = 0;
    @(negedge clk);
    chk("merge_drained", r_empty, 1);
    chk("sb_queue_empty", q.size(), 0);

    // Load hazard against pending and incoming stores
    tick();
    drive(SW, 32'h6008, 32'h55);
    expect_st(32'h6008, 4'hF, 32'h55);
    tick();
    drive(SW, 32'h6010, 32'h66);
    expect_st(32'h6010, 4'hF, 32'h66);
    ld = 32'h600B;
    @(negedge clk);
    chk("haz_pend", r_haz, 1);
    tick();
    drive(SW, 32'h600C, 32'h77);
    ld = 32'h600C;
    #1;
    chk("haz_incoming", r_haz, 1);
    s_valid = 0;
    #1;
    chk("haz_miss", r_haz, 0);
    ld = 32'h6010;
    #1;
    chk("haz_second", r_haz, 1);

    // Reset in the middle of draining
    tick();
    r_ack = 1;
    tick();
    rn = 1'b0;
    #1;
    chk("mid_rst_req", r_req, 0);
    chk("mid_rst_empty", r_empty, 1);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_we", r_we, 0);
    chk("mid_rst_count", r_cnt, 0);
    q.delete();
    r_ack = 0;
    tick();
    rn = 1'b1;
    @(negedge clk);
    chk("post_rst_haz", r_haz, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
